// File: rtl/tile_pkg.sv
// Shared constants for the 2x2 board of 8x8 tiles: geometry, palette and
// flash-controller state encoding.
package tile_pkg;

   localparam int TILE_SIZE = 8;
   localparam int SIDE_W    = $clog2(TILE_SIZE);
   localparam int CNT_W     = 2 * SIDE_W;

   typedef logic [1:0] tile_idx_t;

   localparam logic [2:0] COLOUR_BLACK = 3'b000;
   localparam logic [2:0] COLOUR_WHITE = 3'b111;

   localparam logic [7:0] TILE0_OX = 8'd0;
   localparam logic [6:0] TILE0_OY = 7'd0;
   localparam logic [2:0] TILE0_LIT = 3'b001;
   localparam logic [7:0] TILE1_OX = 8'(TILE_SIZE);
   localparam logic [6:0] TILE1_OY = 7'd0;
   localparam logic [2:0] TILE1_LIT = 3'b010;
   localparam logic [7:0] TILE2_OX = 8'd0;
   localparam logic [6:0] TILE2_OY = 7'(TILE_SIZE);
   localparam logic [2:0] TILE2_LIT = 3'b011;
   localparam logic [7:0] TILE3_OX = 8'(TILE_SIZE);
   localparam logic [6:0] TILE3_OY = 7'(TILE_SIZE);
   localparam logic [2:0] TILE3_LIT = 3'b100;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_DRAW_ON  = 3'd1;
   localparam logic [2:0] ST_HOLD     = 3'd2;
   localparam logic [2:0] ST_DRAW_OFF = 3'd3;
   localparam logic [2:0] ST_DONE     = 3'd4;

   // True for the first or last row/column of a tile (outline pixels).
   function automatic logic is_edge(input logic [SIDE_W-1:0] v);
      return (v == '0) || (v == SIDE_W'(TILE_SIZE - 1));
   endfunction

endpackage

// File: rtl/tile_geom.sv
// Tile index -> on-screen origin and lit colour. Purely combinational so the
// board-init drawer can share it.
module tile_geom
   import tile_pkg::*;
(
   input  logic [1:0] tile,
   output logic [7:0] ox,
   output logic [6:0] oy,
   output logic [2:0] lit
);

   always_comb begin
      ox  = TILE0_OX;
      oy  = TILE0_OY;
      lit = TILE0_LIT;
      case (tile)
         2'd1: begin ox = TILE1_OX; oy = TILE1_OY; lit = TILE1_LIT; end
         2'd2: begin ox = TILE2_OX; oy = TILE2_OY; lit = TILE2_LIT; end
         2'd3: begin ox = TILE3_OX; oy = TILE3_OY; lit = TILE3_LIT; end
         default: begin ox = TILE0_OX; oy = TILE0_OY; lit = TILE0_LIT; end
      endcase
   end

endmodule

// File: rtl/tile_flash_ctrl.sv
// Flashes one board tile: raster lit, hold, raster black, pulse done.
// Define TILE_BORDER_EN to draw a white outline during the lit raster.
module tile_flash_ctrl
   import tile_pkg::*;
#(
   parameter int HOLD_CYCLES = 25000000,
   parameter int HOLD_W      = 25
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       req,
   input  logic [1:0] tile,
   input  logic       abort,
   output logic       ready,
   output logic       done,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic [2:0] colour,
   output logic       plot
);

   localparam logic [CNT_W-1:0]  CNT_LAST  = '1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

   logic [2:0]        state_q, state_d;
   tile_idx_t         tile_q, tile_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              done_q, done_d;
   logic              plot_q, plot_d;
   logic [7:0]        x_q, x_d;
   logic [6:0]        y_q, y_d;
   logic [2:0]        colour_q, colour_d;

   tile_idx_t         geom_tile;
   logic [7:0]        ox;
   logic [6:0]        oy;
   logic [2:0]        lit;
   logic              pix_load, pix_black;
   logic [SIDE_W-1:0] col, row;
   logic [2:0]        on_colour;

   // Geometry must be valid on the acceptance edge, before tile_q is loaded.
   assign geom_tile = (state_q == ST_IDLE) ? tile : tile_q;

   tile_geom u_geom (
      .tile (geom_tile),
      .ox   (ox),
      .oy   (oy),
      .lit  (lit)
   );

   always_comb begin
      state_d   = state_q;
      tile_d    = tile_q;
      cnt_d     = cnt_q;
      hold_d    = hold_q;
      done_d    = 1'b0;
      plot_d    = 1'b0;
      x_d       = x_q;
      y_d       = y_q;
      colour_d  = colour_q;
      pix_load  = 1'b0;
      pix_black = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (req && !abort) begin
               tile_d   = tile;
               state_d  = ST_DRAW_ON;
               cnt_d    = '0;
               pix_load = 1'b1;
            end
         end
         ST_DRAW_ON: begin
            if (cnt_q == CNT_LAST) begin
               state_d = ST_HOLD;
               hold_d  = '0;
            end else begin
               cnt_d    = cnt_q + CNT_W'(1);
               pix_load = 1'b1;
            end
         end
         ST_HOLD: begin
            if (hold_q == HOLD_LAST) begin
               state_d   = ST_DRAW_OFF;
               cnt_d     = '0;
               pix_load  = 1'b1;
               pix_black = 1'b1;
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         ST_DRAW_OFF: begin
            if (cnt_q == CNT_LAST) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end else begin
               cnt_d     = cnt_q + CNT_W'(1);
               pix_load  = 1'b1;
               pix_black = 1'b1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if (abort && (state_q != ST_IDLE)) begin
         state_d  = ST_IDLE;
         cnt_d    = '0;
         hold_d   = '0;
         done_d   = 1'b0;
         pix_load = 1'b0;
      end

      // Outputs are registered, so the pixel shown next cycle is cnt_d.
      col = cnt_d[SIDE_W-1:0];
      row = cnt_d[CNT_W-1:SIDE_W];
`ifdef TILE_BORDER_EN
      on_colour = (is_edge(row) || is_edge(col)) ? COLOUR_WHITE : lit;
`else
      on_colour = lit;
`endif
      if (pix_load) begin
         plot_d   = 1'b1;
         x_d      = ox + {{(8 - SIDE_W){1'b0}}, col};
         y_d      = oy + {{(7 - SIDE_W){1'b0}}, row};
         colour_d = pix_black ? COLOUR_BLACK : on_colour;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= ST_IDLE;
         tile_q   <= '0;
         cnt_q    <= '0;
         hold_q   <= '0;
         done_q   <= 1'b0;
         plot_q   <= 1'b0;
         x_q      <= '0;
         y_q      <= '0;
         colour_q <= '0;
      end else begin
         state_q  <= state_d;
         tile_q   <= tile_d;
         cnt_q    <= cnt_d;
         hold_q   <= hold_d;
         done_q   <= done_d;
         plot_q   <= plot_d;
         x_q      <= x_d;
         y_q      <= y_d;
         colour_q <= colour_d;
      end
   end

   assign ready  = (state_q == ST_IDLE);
   assign done   = done_q;
   assign plot   = plot_q;
   assign x      = x_q;
   assign y      = y_q;
   assign colour = colour_q;

endmodule

// File: tb/tb_tile_flash_ctrl.sv
// Randomized bench for tile_flash_ctrl against a per-cycle expected-trace model.
module tb_tile_flash_ctrl;

   localparam int H     = 4;
   localparam int TOTAL = 64 + H + 64 + 1;

   logic       clk = 1'b0;
   logic       resetn;
   logic       req;
   logic [1:0] tile;
   logic       abort;
   logic       ready, done, plot;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;

   int checks = 0;
   int failures = 0;

   tile_flash_ctrl #(.HOLD_CYCLES(H), .HOLD_W(3)) dut (
      .clk    (clk),
      .resetn (resetn),
      .req    (req),
      .tile   (tile),
      .abort  (abort),
      .ready  (ready),
      .done   (done),
      .x      (x),
      .y      (y),
      .colour (colour),
      .plot   (plot)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_ready"}, int'(ready), 1);
      check({tag, "_plot"}, int'(plot), 0);
      check({tag, "_done"}, int'(done), 0);
      check({tag, "_x"}, int'(x), 0);
      check({tag, "_y"}, int'(y), 0);
      check({tag, "_colour"}, int'(colour), 0);
   endtask

   // Expected outputs for busy cycle i (0 = cycle after acceptance) of tile t.
   function automatic void model(input int t, input int i, output int e_plot,
                                 output int e_x, output int e_y,
                                 output int e_col, output int e_done);
      int ox, oy, lit, p, r, c;
      ox = (t % 2) * 8;
      oy = (t / 2) * 8;
      lit = t + 1;
      e_plot = 0; e_x = 0; e_y = 0; e_col = 0; e_done = 0;
      if (i < 64 || (i >= 64 + H && i < 128 + H)) begin
         p = (i < 64) ? i : i - 64 - H;
         r = p / 8;
         c = p % 8;
         e_plot = 1;
         e_x = ox + c;
         e_y = oy + r;
         if (i < 64) begin
            e_col = lit;
`ifdef TILE_BORDER_EN
            if (r == 0 || r == 7 || c == 0 || c == 7) e_col = 7;
`endif
         end
      end else if (i == 128 + H) begin
         e_done = 1;
      end
   endfunction

   // Runs from an IDLE cycle (#1 after an edge). noise: 0 req low while busy,
   // 1 random req/tile, 2 req held high with tile 2.
   task automatic run_flash(input int t, input int abort_at, input int reset_at,
                            input int noise);
      int e_plot, e_x, e_y, e_col, e_done;
      check($sformatf("t%0d_start_ready", t), int'(ready), 1);
      check($sformatf("t%0d_start_plot", t), int'(plot), 0);
      req = 1'b1;
      tile = 2'(t);
      abort = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < TOTAL; i++) begin
         model(t, i, e_plot, e_x, e_y, e_col, e_done);
         check($sformatf("t%0d_i%0d_plot", t, i), int'(plot), e_plot);
         check($sformatf("t%0d_i%0d_done", t, i), int'(done), e_done);
         check($sformatf("t%0d_i%0d_ready", t, i), int'(ready), 0);
         if (e_plot == 1) begin
            check($sformatf("t%0d_i%0d_x", t, i), int'(x), e_x);
            check($sformatf("t%0d_i%0d_y", t, i), int'(y), e_y);
            check($sformatf("t%0d_i%0d_colour", t, i), int'(colour), e_col);
         end
         if (i == abort_at) begin
            abort = 1'b1;
            req = 1'($urandom % 2);
            @(posedge clk); #1;
            abort = 1'b0;
            req = 1'b0;
            check($sformatf("t%0d_abort_plot", t), int'(plot), 0);
            check($sformatf("t%0d_abort_ready", t), int'(ready), 1);
            check($sformatf("t%0d_abort_done", t), int'(done), 0);
            $display("flash tile=%0d aborted at cycle %0d", t, i);
            return;
         end
         if (i == reset_at) begin
            req = 1'b0;
            resetn = 1'b0;
            #1;
            check_reset_vals($sformatf("t%0d_async_rst", t));
            #2;
            resetn = 1'b1;
            @(posedge clk); #1;
            $display("flash tile=%0d reset at cycle %0d", t, i);
            return;
         end
         case (noise)
            1: begin req = 1'($urandom % 2); tile = 2'($urandom % 4); end
            2: begin req = 1'b1; tile = 2'd2; end
            default: req = 1'b0;
         endcase
         @(posedge clk); #1;
      end
      check($sformatf("t%0d_end_ready", t), int'(ready), 1);
      check($sformatf("t%0d_end_done", t), int'(done), 0);
      check($sformatf("t%0d_end_plot", t), int'(plot), 0);
      if (noise != 2) req = 1'b0;
      $display("flash tile=%0d completed in %0d cycles", t, TOTAL);
   endtask

   initial begin
      int t, ab, gap;
      resetn = 1'b0;
      req = 1'b0;
      abort = 1'b0;
      tile = 2'd0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("in_reset");
      #2;
      resetn = 1'b1;
      @(posedge clk); #1;
      check_reset_vals("after_reset");

      run_flash(3, -1, -1, 0);
      run_flash(1, -1, -1, 2);   // tile 2 held on req throughout; must be ignored
      run_flash(2, -1, -1, 0);
      run_flash(0, 9, -1, 0);
      run_flash(2, -1, -1, 0);

      // abort in IDLE suppresses a simultaneous req
      req = 1'b1;
      tile = 2'd1;
      abort = 1'b1;
      @(posedge clk); #1;
      req = 1'b0;
      abort = 1'b0;
      check("idle_abort_ready", int'(ready), 1);
      check("idle_abort_plot", int'(plot), 0);
      @(posedge clk); #1;
      check("idle_abort_ready2", int'(ready), 1);
      $display("abort with req in IDLE ignored");

      run_flash(int'($urandom % 4), -1, 64 + 2, 0);
      run_flash(1, -1, -1, 0);

      for (int n = 0; n < 12; n++) begin
         t = int'($urandom % 4);
         ab = ($urandom % 3 == 0) ? int'($urandom % TOTAL) : -1;
         run_flash(t, ab, -1, 1);
         gap = int'($urandom % 4);
         for (int g = 0; g < gap; g++) begin
            tile = 2'($urandom % 4);
            @(posedge clk); #1;
            check("gap_ready", int'(ready), 1);
            check("gap_plot", int'(plot), 0);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
